// File: rtl/clk_mon_pkg.sv
// Shared types and defaults for the divided-clock period monitor.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } clk_mon_state_t;

    localparam int CLK_MON_CNT_W   = 11;
    localparam int CLK_MON_TIMEOUT = 2047;

endpackage

// File: rtl/clk_mon_edge.sv
// Rising-edge detector for the divided waveform; the input passes through a
// 2-flop synchronizer when CLK_MON_SYNC_EN is defined.
module clk_mon_edge (
    input  logic clk,
    input  logic rst,
    input  logic div_in,
    output logic div_s,
    output logic rise
);

`ifdef CLK_MON_SYNC_EN
    logic sync1_d, sync1_q;
    logic sync2_d, sync2_q;

    always_comb begin
        sync1_d = div_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign div_s = sync2_q;
`else
    assign div_s = div_in;
`endif

    logic div_d_d, div_d_q;

    always_comb begin
        div_d_d = div_s;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_d_q <= 1'b0;
        end else begin
            div_d_q <= div_d_d;
        end
    end

    assign rise = div_s & ~div_d_q;

endmodule

// File: rtl/clk_period_monitor.sv
// Measures rise-to-rise period and high time of div_in in clk cycles, with a
// sticky stall flag. Define CLK_MON_SYNC_EN to synchronize an asynchronous div_in.
module clk_period_monitor
    import clk_mon_pkg::*;
#(
    parameter int CNT_W   = CLK_MON_CNT_W,
    parameter int TIMEOUT = CLK_MON_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_in,
    input  logic             clr_timeout,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_vld,
    output logic             timeout,
    output logic             busy
);

    logic div_s;
    logic rise;

    clk_mon_edge u_edge (
        .clk    (clk),
        .rst    (rst),
        .div_in (div_in),
        .div_s  (div_s),
        .rise   (rise)
    );

    clk_mon_state_t   state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [CNT_W-1:0] hi_d, hi_q;
    logic [CNT_W-1:0] period_d, period_q;
    logic [CNT_W-1:0] high_time_d, high_time_q;
    logic             vld_d, vld_q;
    logic             timeout_d, timeout_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        vld_d       = 1'b0;
        timeout_d   = timeout_q & ~clr_timeout;

        // Disable wins over everything, including a same-cycle rise.
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARM;
                end
                ST_ARM: begin
                    if (rise) begin
                        cnt_d   = CNT_W'(1);
                        hi_d    = CNT_W'(1);
                        state_d = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (rise) begin
                        period_d    = cnt_q;
                        high_time_d = hi_q;
                        vld_d       = 1'b1;
                        cnt_d       = CNT_W'(1);
                        hi_d        = CNT_W'(1);
                    end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                        // Set beats a same-cycle clear.
                        timeout_d = 1'b1;
                        state_d   = ST_ARM;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        hi_d  = hi_q + {{(CNT_W-1){1'b0}}, div_s};
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            vld_q       <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            vld_q       <= vld_d;
            timeout_q   <= timeout_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign period_vld = vld_q;
    assign timeout    = timeout_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
